// File: rtl/ethernet_mmio_bridge.sv
// ethernet_mmio_bridge: decodes the Ethernet MMIO window, screens illegal
// requests, forwards legal ones through a one-entry request register to the
// controller and returns one in-order response per accepted request using a
// small tag FIFO of {write_not_read, error} entries.

// Checker: a controller response must only appear while a legal tag heads the queue.
module ethernet_mmio_bridge_chk (
  input logic clk_i,
  input logic reset_i,
  input logic i_eth_valid,
  input logic i_head_legal
);

  a_resp_paired: assert property (@(posedge clk_i) disable iff (reset_i)
    i_eth_valid |-> i_head_legal);

endmodule

module ethernet_mmio_bridge #(
  parameter int                      data_width_p = 32,
  parameter int                      addr_width_p = 40,
  parameter logic [addr_width_p-1:0] base_addr_p  = 40'h00_1000_0000,
  parameter int                      els_p        = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_and_o,
  input  logic                    in_write_not_read_i,
  input  logic [addr_width_p-1:0] in_addr_i,
  input  logic [1:0]              in_size_i,
  input  logic [data_width_p-1:0] in_data_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_and_i,
  output logic                    out_write_not_read_o,
  output logic                    out_err_o,
  output logic [data_width_p-1:0] out_data_o,
  output logic [13:0]             eth_addr_o,
  output logic                    eth_write_en_o,
  output logic                    eth_read_en_o,
  output logic [1:0]              eth_op_size_o,
  output logic [data_width_p-1:0] eth_write_data_o,
  input  logic                    eth_ready_and_i,
  input  logic                    eth_valid_i,
  input  logic [data_width_p-1:0] eth_read_data_i,
  output logic                    eth_ready_and_o
);

  localparam int ptr_w_lp = $clog2(els_p);
  localparam int cnt_w_lp = ptr_w_lp + 1;

  // request register toward the controller
  logic                    r_req_v;
  logic                    r_wnr;
  logic [13:0]             r_addr;
  logic [1:0]              r_size;
  logic [data_width_p-1:0] r_wdata;

  // response-order tag FIFO
  logic [cnt_w_lp-1:0]     r_count;
  logic [ptr_w_lp-1:0]     r_wptr;
  logic [ptr_w_lp-1:0]     r_rptr;
  logic [els_p-1:0]        r_tag_wnr;
  logic [els_p-1:0]        r_tag_err;

  logic w_in_window;
  logic w_aligned;
  logic w_err_req;
  logic w_not_full;
  logic w_in_ready;
  logic w_accept;
  logic w_tag_v;
  logic w_err_h;
  logic w_wnr_h;
  logic w_out_valid;
  logic w_deq;

  assign w_in_window = (in_addr_i[addr_width_p-1:14] == base_addr_p[addr_width_p-1:14]);

  // natural alignment of the byte address for the requested access size
  always_comb begin
    w_aligned = 1'b0;
    case (in_size_i)
      2'd0:    w_aligned = 1'b1;
      2'd1:    w_aligned = ~in_addr_i[0];
      2'd2:    w_aligned = (in_addr_i[1:0] == 2'b00);
      default: w_aligned = 1'b0;
    endcase
  end

  // size 3 is never aligned, so it falls into the error class here
  assign w_err_req  = ~(w_in_window & w_aligned);
  assign w_not_full = (r_count < cnt_w_lp'(els_p));
  // error requests bypass the request register, so only legal ones wait on it
  assign w_in_ready = ~reset_i & w_not_full & (w_err_req | ~r_req_v | eth_ready_and_i);
  assign w_accept   = in_valid_i & w_in_ready;

  assign w_tag_v     = ~reset_i & (r_count != {cnt_w_lp{1'b0}});
  assign w_err_h     = r_tag_err[r_rptr];
  assign w_wnr_h     = r_tag_wnr[r_rptr];
  assign w_out_valid = w_tag_v & (w_err_h | eth_valid_i);
  assign w_deq       = w_out_valid & out_ready_and_i;

  assign in_ready_and_o       = w_in_ready;
  assign out_valid_o          = w_out_valid;
  assign out_err_o            = w_tag_v & w_err_h;
  assign out_write_not_read_o = w_tag_v & w_wnr_h;
  assign eth_ready_and_o      = w_tag_v & ~w_err_h & out_ready_and_i;

  assign eth_addr_o       = r_addr;
  assign eth_op_size_o    = r_size;
  assign eth_write_data_o = r_wdata;
  assign eth_write_en_o   = r_req_v & r_wnr;
  assign eth_read_en_o    = r_req_v & ~r_wnr;

  // read data passes through only for a legal read at the head
  always_comb begin
    out_data_o = {data_width_p{1'b0}};
    if (w_tag_v & ~w_err_h & ~w_wnr_h) begin
      out_data_o = eth_read_data_i;
    end else begin
      out_data_o = {data_width_p{1'b0}};
    end
  end

  // request register: load on legal accept (even while draining), empty on controller accept
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_req_v <= 1'b0;
      r_wnr   <= 1'b0;
      r_addr  <= 14'd0;
      r_size  <= 2'd0;
      r_wdata <= {data_width_p{1'b0}};
    end else if (w_accept & ~w_err_req) begin
      r_req_v <= 1'b1;
      r_wnr   <= in_write_not_read_i;
      r_addr  <= in_addr_i[13:0];
      r_size  <= in_size_i;
      r_wdata <= in_data_i;
    end else if (r_req_v & eth_ready_and_i) begin
      r_req_v <= 1'b0;
    end
  end

  // tag FIFO: enqueue every accepted request, dequeue on response handshake
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_count   <= {cnt_w_lp{1'b0}};
      r_wptr    <= {ptr_w_lp{1'b0}};
      r_rptr    <= {ptr_w_lp{1'b0}};
      r_tag_wnr <= {els_p{1'b0}};
      r_tag_err <= {els_p{1'b0}};
    end else begin
      if (w_accept) begin
        r_tag_wnr[r_wptr] <= in_write_not_read_i;
        r_tag_err[r_wptr] <= w_err_req;
        r_wptr            <= r_wptr + ptr_w_lp'(1);
      end
      if (w_deq) begin
        r_rptr <= r_rptr + ptr_w_lp'(1);
      end
      case ({w_accept, w_deq})
        2'b10:   r_count <= r_count + cnt_w_lp'(1);
        2'b01:   r_count <= r_count - cnt_w_lp'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  ethernet_mmio_bridge_chk u_chk (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .i_eth_valid  (eth_valid_i),
    .i_head_legal (w_tag_v & ~w_err_h)
  );

endmodule

// File: tb/tb_ethernet_mmio_bridge.sv
// Self-checking bench for ethernet_mmio_bridge: directed scenarios plus a
// randomized phase, all compared every cycle against a queue-based model.
module tb_ethernet_mmio_bridge;

  localparam int          ELS  = 4;
  localparam logic [39:0] BASE = 40'h00_1000_0000;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_i = 1'b1;
  logic        in_valid_i = 1'b0;
  logic        in_ready_and_o;
  logic        in_write_not_read_i = 1'b0;
  logic [39:0] in_addr_i = '0;
  logic [1:0]  in_size_i = '0;
  logic [31:0] in_data_i = '0;
  logic        out_valid_o;
  logic        out_ready_and_i = 1'b0;
  logic        out_write_not_read_o;
  logic        out_err_o;
  logic [31:0] out_data_o;
  logic [13:0] eth_addr_o;
  logic        eth_write_en_o;
  logic        eth_read_en_o;
  logic [1:0]  eth_op_size_o;
  logic [31:0] eth_write_data_o;
  logic        eth_ready_and_i = 1'b0;
  logic        eth_valid_i = 1'b0;
  logic [31:0] eth_read_data_i = '0;
  logic        eth_ready_and_o;

  ethernet_mmio_bridge #(.data_width_p(32), .addr_width_p(40), .base_addr_p(BASE), .els_p(ELS)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .in_valid_i(in_valid_i), .in_ready_and_o(in_ready_and_o),
    .in_write_not_read_i(in_write_not_read_i), .in_addr_i(in_addr_i),
    .in_size_i(in_size_i), .in_data_i(in_data_i),
    .out_valid_o(out_valid_o), .out_ready_and_i(out_ready_and_i),
    .out_write_not_read_o(out_write_not_read_o), .out_err_o(out_err_o), .out_data_o(out_data_o),
    .eth_addr_o(eth_addr_o), .eth_write_en_o(eth_write_en_o), .eth_read_en_o(eth_read_en_o),
    .eth_op_size_o(eth_op_size_o), .eth_write_data_o(eth_write_data_o),
    .eth_ready_and_i(eth_ready_and_i), .eth_valid_i(eth_valid_i),
    .eth_read_data_i(eth_read_data_i), .eth_ready_and_o(eth_ready_and_o)
  );

  typedef struct packed { logic wnr; logic err; } tag_t;
  typedef struct packed { logic [13:0] addr; logic wnr; logic [1:0] size; logic [31:0] wdata; logic [31:0] rdata; } op_t;
  typedef struct packed { logic wnr; logic err; logic [31:0] data; } rsp_t;

  tag_t tagq[$];   // accepted requests awaiting a response, in order
  op_t  issq[$];   // legal requests accepted but not yet taken by the controller
  op_t  pendq[$];  // requests taken by the controller, response not yet consumed
  rsp_t done_q[$]; // responses consumed, in order

  int n_checks = 0;
  int n_pass   = 0;

  // stimulus knobs
  bit          d_rst = 1'b1, d_in_valid = 1'b0, d_wnr = 1'b0;
  logic [39:0] d_addr = '0;
  logic [1:0]  d_size = '0;
  logic [31:0] d_wdata = '0, d_rdata = '0;
  bit          d_out_ready = 1'b1, d_eth_ready = 1'b1, d_resp_go = 1'b1, d_fix_rdata = 1'b0;

  // snapshots of DUT outputs for directed literal checks
  logic        s_in_ready, s_out_valid, s_out_err, s_out_wnr, s_wen, s_ren;
  logic [31:0] s_out_data, s_wdata;
  logic [13:0] s_addr;
  logic [1:0]  s_size;
  bit          s_acc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic bit is_legal(input logic [39:0] a, input logic [1:0] s);
    if (s == 2'd3) return 1'b0;
    if ((a >> 14) != (BASE >> 14)) return 1'b0;
    if ((a % (40'd1 << s)) != 40'd0) return 1'b0;
    return 1'b1;
  endfunction

  // one clock: drive, compare against the model, then advance the model
  task automatic step();
    bit   e_in_ready, e_out_valid, e_eth_rdy, err_req, acc, deq, iss;
    tag_t h, t;
    op_t  o;
    rsp_t r;
    logic [31:0] e_data;
    @(negedge clk);
    reset_i = d_rst; in_valid_i = d_in_valid; in_write_not_read_i = d_wnr;
    in_addr_i = d_addr; in_size_i = d_size; in_data_i = d_wdata;
    out_ready_and_i = d_out_ready; eth_ready_and_i = d_eth_ready;
    if (!d_rst && d_resp_go && pendq.size() > 0 && tagq.size() > 0 && !tagq[0].err) begin
      eth_valid_i = 1'b1; eth_read_data_i = pendq[0].rdata;
    end else begin
      eth_valid_i = 1'b0; eth_read_data_i = $urandom;
    end
    #1;
    s_in_ready = in_ready_and_o; s_out_valid = out_valid_o; s_out_err = out_err_o;
    s_out_wnr = out_write_not_read_o; s_out_data = out_data_o; s_wen = eth_write_en_o;
    s_ren = eth_read_en_o; s_addr = eth_addr_o; s_size = eth_op_size_o; s_wdata = eth_write_data_o;
    err_req = !is_legal(d_addr, d_size);
    acc = 1'b0; deq = 1'b0; iss = 1'b0;
    if (d_rst) begin
      chk("in_ready_in_reset", 64'(in_ready_and_o), 64'(0));
    end else begin
      e_in_ready  = (tagq.size() < ELS) && (err_req || issq.size() == 0 || d_eth_ready);
      e_out_valid = (tagq.size() > 0) && (tagq[0].err || eth_valid_i);
      e_eth_rdy   = (tagq.size() > 0) && !tagq[0].err && d_out_ready;
      chk("in_ready", 64'(in_ready_and_o), 64'(e_in_ready));
      chk("out_valid", 64'(out_valid_o), 64'(e_out_valid));
      chk("eth_ready_o", 64'(eth_ready_and_o), 64'(e_eth_rdy));
      chk("eth_wen", 64'(eth_write_en_o), 64'(issq.size() > 0 && issq[0].wnr));
      chk("eth_ren", 64'(eth_read_en_o), 64'(issq.size() > 0 && !issq[0].wnr));
      if (issq.size() > 0) begin
        chk("eth_addr", 64'(eth_addr_o), 64'(issq[0].addr));
        chk("eth_size", 64'(eth_op_size_o), 64'(issq[0].size));
        if (issq[0].wnr) chk("eth_wdata", 64'(eth_write_data_o), 64'(issq[0].wdata));
      end
      if (e_out_valid) begin
        e_data = (!tagq[0].err && !tagq[0].wnr) ? pendq[0].rdata : 32'd0;
        chk("out_err", 64'(out_err_o), 64'(tagq[0].err));
        chk("out_wnr", 64'(out_write_not_read_o), 64'(tagq[0].wnr));
        chk("out_data", 64'(out_data_o), 64'(e_data));
      end
      acc = d_in_valid && e_in_ready;
      deq = e_out_valid && d_out_ready;
      iss = (issq.size() > 0) && d_eth_ready;
    end
    s_acc = acc;
    @(posedge clk);
    if (d_rst) begin
      tagq.delete(); issq.delete(); pendq.delete();
    end else begin
      if (deq) begin
        h = tagq.pop_front();
        r.wnr = h.wnr; r.err = h.err;
        r.data = (!h.err && !h.wnr) ? pendq[0].rdata : 32'd0;
        if (!h.err) void'(pendq.pop_front());
        done_q.push_back(r);
      end
      if (iss) begin
        o = issq.pop_front();
        o.rdata = d_fix_rdata ? d_rdata : 32'($urandom);
        pendq.push_back(o);
      end
      if (acc) begin
        t.wnr = d_wnr; t.err = err_req;
        tagq.push_back(t);
        if (!err_req) begin
          o.addr = d_addr[13:0]; o.wnr = d_wnr; o.size = d_size; o.wdata = d_wdata; o.rdata = 32'd0;
          issq.push_back(o);
        end
      end
    end
  endtask

  task automatic req(input bit wnr, input logic [39:0] addr, input logic [1:0] size, input logic [31:0] wdata);
    d_in_valid = 1'b1; d_wnr = wnr; d_addr = addr; d_size = size; d_wdata = wdata;
    step();
    d_in_valid = 1'b0;
  endtask

  initial begin
    int acc_n;
    int n0;
    // reset
    d_rst = 1'b1; step(); step(); d_rst = 1'b0;
    step();
    chk("rst_out_valid", 64'(s_out_valid), 64'(0));
    chk("rst_wen", 64'(s_wen), 64'(0));
    chk("rst_ren", 64'(s_ren), 64'(0));
    chk("rst_addr", 64'(s_addr), 64'(0));
    chk("rst_in_ready", 64'(s_in_ready), 64'(1));

    // legal read
    d_fix_rdata = 1'b1; d_rdata = 32'hDEADBEEF; d_resp_go = 1'b0;
    req(1'b0, BASE + 40'h10, 2'd2, 32'd0);
    chk("rd_accept", 64'(s_in_ready), 64'(1));
    step();
    chk("rd_ren", 64'(s_ren), 64'(1));
    chk("rd_addr", 64'(s_addr), 64'h0010);
    d_resp_go = 1'b1; step();
    chk("rd_valid", 64'(s_out_valid), 64'(1));
    chk("rd_data", 64'(s_out_data), 64'hDEADBEEF);
    chk("rd_err", 64'(s_out_err), 64'(0));

    // legal write at the top of the window
    d_resp_go = 1'b0;
    req(1'b1, BASE + 40'h3FFC, 2'd2, 32'h12345678);
    step();
    chk("wr_wen", 64'(s_wen), 64'(1));
    chk("wr_addr", 64'(s_addr), 64'h3FFC);
    chk("wr_size", 64'(s_size), 64'(2));
    chk("wr_wdata", 64'(s_wdata), 64'h12345678);
    d_resp_go = 1'b1; step();
    chk("wr_valid", 64'(s_out_valid), 64'(1));
    chk("wr_wnr", 64'(s_out_wnr), 64'(1));
    chk("wr_data", 64'(s_out_data), 64'(0));

    // local errors: out of window, misaligned, illegal size
    for (int k = 0; k < 3; k++) begin
      case (k)
        0:       req(1'b0, BASE + 40'h4000, 2'd2, 32'd0);
        1:       req(1'b0, BASE + 40'h0002, 2'd2, 32'd0);
        default: req(1'b1, BASE + 40'h0020, 2'd3, 32'hFFFF);
      endcase
      chk("err_no_en_acc", 64'(s_wen | s_ren), 64'(0));
      step();
      chk("err_valid", 64'(s_out_valid), 64'(1));
      chk("err_flag", 64'(s_out_err), 64'(1));
      chk("err_no_en", 64'(s_wen | s_ren), 64'(0));
    end

    // ordering: legal A, error B, legal C with delayed controller responses
    done_q.delete(); d_resp_go = 1'b0;
    d_rdata = 32'hAAAA0001; req(1'b0, BASE + 40'h40, 2'd2, 32'd0);
    req(1'b0, BASE + 40'h41, 2'd1, 32'd0);
    d_rdata = 32'hCCCC0003; req(1'b0, BASE + 40'h48, 2'd2, 32'd0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("order_hold", 64'(s_out_valid), 64'(0));
    end
    d_resp_go = 1'b1; step();
    chk("order_A_first", 64'(s_out_data), 64'hAAAA0001);
    for (int k = 0; k < 4; k++) step();
    chk("order_n", 64'(done_q.size()), 64'(3));
    if (done_q.size() == 3) begin
      chk("order_A", 64'(done_q[0].data), 64'hAAAA0001);
      chk("order_B", 64'(done_q[1].err), 64'(1));
      chk("order_C", 64'(done_q[2].data), 64'hCCCC0003);
    end

    // full FIFO: 5 reads while responses are back-pressured
    d_fix_rdata = 1'b0; d_out_ready = 1'b0; acc_n = 0; n0 = done_q.size();
    for (int k = 0; k < 10; k++) begin
      d_in_valid = 1'b1; d_wnr = 1'b0; d_size = 2'd2; d_addr = BASE + 40'h100 + 40'(4 * acc_n);
      step();
      if (s_acc) acc_n++;
    end
    chk("full_accepted", 64'(acc_n), 64'(4));
    chk("full_not_ready", 64'(s_in_ready), 64'(0));
    d_out_ready = 1'b1;
    for (int k = 0; k < 30 && acc_n < 5; k++) begin
      d_addr = BASE + 40'h100 + 40'(4 * acc_n);
      step();
      if (s_acc) acc_n++;
    end
    d_in_valid = 1'b0;
    chk("full_fifth", 64'(acc_n), 64'(5));
    for (int k = 0; k < 12; k++) step();
    chk("full_drained", 64'(done_q.size() - n0), 64'(5));
    chk("full_idle", 64'(s_out_valid), 64'(0));

    // reset with two outstanding reads
    d_resp_go = 1'b0;
    req(1'b0, BASE + 40'h200, 2'd2, 32'd0);
    req(1'b0, BASE + 40'h204, 2'd2, 32'd0);
    step();
    d_rst = 1'b1; step(); d_rst = 1'b0;
    step();
    chk("mid_rst_valid", 64'(s_out_valid), 64'(0));
    chk("mid_rst_en", 64'(s_wen | s_ren), 64'(0));
    chk("mid_rst_ready", 64'(s_in_ready), 64'(1));
    d_fix_rdata = 1'b1; d_rdata = 32'h5A5A5A5A;
    req(1'b0, BASE + 40'h208, 2'd2, 32'd0);
    step();
    d_resp_go = 1'b1; step();
    chk("post_rst_valid", 64'(s_out_valid), 64'(1));
    chk("post_rst_data", 64'(s_out_data), 64'h5A5A5A5A);

    // randomized traffic
    d_fix_rdata = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      int sel;
      sel = int'($urandom % 8);
      d_rst       = ($urandom % 700 == 0);
      d_in_valid  = ($urandom % 4 != 0);
      d_wnr       = $urandom % 2;
      d_wdata     = $urandom;
      if (sel == 0)      d_addr = BASE + 40'h4000 + 40'($urandom & 32'hFFFF);
      else if (sel == 1) d_addr = BASE - 40'(($urandom % 64) + 1);
      else               d_addr = BASE + 40'($urandom & 32'h3FFF);
      d_size      = ($urandom % 8 == 0) ? 2'd3 : 2'($urandom % 3);
      d_out_ready = ($urandom % 4 != 0);
      d_eth_ready = ($urandom % 3 != 0);
      d_resp_go   = $urandom % 2;
      step();
    end
    d_rst = 1'b0; d_in_valid = 1'b0; d_out_ready = 1'b1; d_eth_ready = 1'b1; d_resp_go = 1'b1;
    for (int k = 0; k < 20; k++) step();
    chk("final_idle", 64'(s_out_valid), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
